// File: rtl/button_conditioner_pkg.sv
// Shared constants and width helpers for the push-button conditioner.
// Widths are derived from the module parameters through these functions.
package button_conditioner_pkg;

  localparam int DEFAULT_CLOCK_FREQ      = 50_000_000;
  localparam int DEFAULT_STABLE_TIME     = 10;
  localparam int DEFAULT_LONG_PRESS_TIME = 1000;
  localparam int DEFAULT_REPEAT_TIME     = 200;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  // Width of a counter that holds 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : clog2(n);
  endfunction

  function automatic int ticks_per_ms(input int clock_freq);
    return clock_freq / 1000;
  endfunction

  localparam int DEFAULT_TICKS_PER_MS = ticks_per_ms(DEFAULT_CLOCK_FREQ);
  localparam int DEFAULT_PRESCALE_W   = cnt_width(DEFAULT_TICKS_PER_MS);
  localparam int DEFAULT_STABLE_W     = cnt_width(DEFAULT_STABLE_TIME);
  localparam int DEFAULT_HOLD_W       = clog2(DEFAULT_LONG_PRESS_TIME + 1);
  localparam int DEFAULT_REPEAT_W     = cnt_width(DEFAULT_REPEAT_TIME);

endpackage

// File: rtl/button_conditioner_channel.sv
// One button channel: 2-FF synchroniser, tick-based debounce, edge pulses,
// and hold / auto-repeat pulse generation.
module button_channel
  import button_conditioner_pkg::*;
#(
  parameter int STABLE_TIME     = DEFAULT_STABLE_TIME,
  parameter int LONG_PRESS_TIME = DEFAULT_LONG_PRESS_TIME,
  parameter int REPEAT_TIME     = DEFAULT_REPEAT_TIME,
  parameter int ACTIVE_LOW      = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic pb,
  output logic pb_debounced,
  output logic pb_press,
  output logic pb_release,
  output logic pb_long,
  output logic pb_repeat
);

  localparam int STABLE_W = cnt_width(STABLE_TIME);
  localparam int HOLD_W   = clog2(LONG_PRESS_TIME + 1);
  localparam int REPEAT_W = cnt_width(REPEAT_TIME);
  localparam int REP_LAST = (REPEAT_TIME > 0) ? REPEAT_TIME - 1 : 0;
  localparam logic POL    = (ACTIVE_LOW != 0);

  localparam logic [STABLE_W-1:0] STABLE_LAST = STABLE_W'(STABLE_TIME - 1);
  localparam logic [HOLD_W-1:0]   HOLD_MAX    = HOLD_W'(LONG_PRESS_TIME);
  localparam logic [HOLD_W-1:0]   HOLD_LAST   = HOLD_W'(LONG_PRESS_TIME - 1);
  localparam logic [REPEAT_W-1:0] REPEAT_LAST = REPEAT_W'(REP_LAST);

  logic                sync1_q, sync1_d;
  logic                sync2_q, sync2_d;
  logic                deb_q, deb_d;
  logic [STABLE_W-1:0] cnt_q, cnt_d;
  logic                press_q, press_d;
  logic                release_q, release_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [REPEAT_W-1:0] rep_q, rep_d;
  logic                long_q, long_d;
  logic                repeat_q, repeat_d;

  always_comb begin
    sync1_d   = pb ^ POL;
    sync2_d   = sync1_q;
    deb_d     = deb_q;
    cnt_d     = cnt_q;
    hold_d    = hold_q;
    rep_d     = rep_q;
    long_d    = 1'b0;
    repeat_d  = 1'b0;

    // A synchronised level equal to the debounced one cancels any pending change.
    if (sync2_q == deb_q) begin
      cnt_d = '0;
    end else if (tick) begin
      if (cnt_q == STABLE_LAST) begin
        deb_d = sync2_q;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + STABLE_W'(1);
      end
    end

    press_d   = deb_d & ~deb_q;
    release_d = ~deb_d & deb_q;

    // Gating long/repeat with deb_d lets a release on the same tick suppress them.
    if (!deb_q) begin
      hold_d = '0;
      rep_d  = '0;
    end else if (tick) begin
      if (hold_q != HOLD_MAX) begin
        hold_d = hold_q + HOLD_W'(1);
      end
      if (hold_q == HOLD_LAST) begin
        long_d   = deb_d;
        repeat_d = deb_d;
      end else if (hold_q == HOLD_MAX && REPEAT_TIME != 0) begin
        if (rep_q == REPEAT_LAST) begin
          rep_d    = '0;
          repeat_d = deb_d;
        end else begin
          rep_d = rep_q + REPEAT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      deb_q     <= 1'b0;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      hold_q    <= '0;
      rep_q     <= '0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      deb_q     <= deb_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
      hold_q    <= hold_d;
      rep_q     <= rep_d;
      long_q    <= long_d;
      repeat_q  <= repeat_d;
    end
  end

  assign pb_debounced = deb_q;
  assign pb_press     = press_q;
  assign pb_release   = release_q;
  assign pb_long      = long_q;
  assign pb_repeat    = repeat_q;

endmodule

// File: rtl/button_conditioner.sv
// Multi-channel push-button front end: one shared 1 ms prescaler feeding
// CHANNELS independent button_channel instances.
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int CHANNELS        = 4,
  parameter int CLOCK_FREQ      = DEFAULT_CLOCK_FREQ,
  parameter int STABLE_TIME     = DEFAULT_STABLE_TIME,
  parameter int LONG_PRESS_TIME = DEFAULT_LONG_PRESS_TIME,
  parameter int REPEAT_TIME     = DEFAULT_REPEAT_TIME,
  parameter int ACTIVE_LOW      = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] pb,
  output logic [CHANNELS-1:0] pb_debounced,
  output logic [CHANNELS-1:0] pb_press,
  output logic [CHANNELS-1:0] pb_release,
  output logic [CHANNELS-1:0] pb_long,
  output logic [CHANNELS-1:0] pb_repeat
);

  localparam int TICKS_PER_MS = ticks_per_ms(CLOCK_FREQ);
  localparam int PRESCALE_W   = cnt_width(TICKS_PER_MS);
  localparam logic [PRESCALE_W-1:0] PRESCALE_LAST = PRESCALE_W'(TICKS_PER_MS - 1);

  logic [PRESCALE_W-1:0] pre_q, pre_d;
  logic                  tick;

  assign tick = (pre_q == PRESCALE_LAST);

  always_comb begin
    pre_d = pre_q + PRESCALE_W'(1);
    if (tick) begin
      pre_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    button_channel #(
      .STABLE_TIME    (STABLE_TIME),
      .LONG_PRESS_TIME(LONG_PRESS_TIME),
      .REPEAT_TIME    (REPEAT_TIME),
      .ACTIVE_LOW     (ACTIVE_LOW)
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .tick        (tick),
      .pb          (pb[g]),
      .pb_debounced(pb_debounced[g]),
      .pb_press    (pb_press[g]),
      .pb_release  (pb_release[g]),
      .pb_long     (pb_long[g]),
      .pb_repeat   (pb_repeat[g])
    );
  end

endmodule
